data_ram: RTL and testbench

Parametrised single-port synchronous data memory for the single-cycle core, replacing the fixed 32×32 word store. Adds byte-lane write strobes, a valid/ready request handshake, a registered read with an explicit response strobe, and an optional post-reset zero-fill sweep. It sits between the core's load/store unit and the memory-mapped address decode.

---
 rtl/data_ram.sv | 140 ++++++++++++++
 tb/tb_data_ram.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/data_ram.sv
// Single-port synchronous data memory: byte-lane write strobes, valid/ready request,
// registered read with response strobe. Define DATA_RAM_CLEAR_EN for the post-reset zero-fill sweep.
module data_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [STRB_W-1:0] wstrb,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              init_busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              accept;

  logic              mem_wen;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [STRB_W-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_q [DEPTH];

  assign accept = req_valid && ready_q;

`ifdef DATA_RAM_CLEAR_EN
  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [ADDR_W:0] sweep_cnt_q, sweep_cnt_d;
  logic            sweep_wen;

  // The extra counter bit flags completion once the last address has been written.
  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    sweep_wen   = 1'b0;
    case (state_q)
      ST_INIT: begin
        sweep_wen   = 1'b1;
        sweep_cnt_d = sweep_cnt_q + CNT_ONE;
        if (sweep_cnt_d[ADDR_W]) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
    ready_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      sweep_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
    end
  end

  assign init_busy = (state_q == ST_INIT);
`else
  always_comb begin
    ready_d = 1'b1;
  end

  assign init_busy = 1'b0;
`endif

  // Single write port shared between the request path and the clear sweep.
  always_comb begin
    mem_wen   = accept && we;
    mem_waddr = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
`ifdef DATA_RAM_CLEAR_EN
    if (sweep_wen) begin
      mem_wen   = 1'b1;
      mem_waddr = sweep_cnt_q[ADDR_W-1:0];
      mem_wdata = '0;
      mem_wstrb = '1;
    end
`endif
  end

  always_comb begin
    rsp_valid_d = accept && !we;
    rdata_d     = rdata_q;
    if (rsp_valid_d) begin
      rdata_d = mem_q[addr];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wen) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (mem_wstrb[i]) begin
          mem_q[mem_waddr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_data_ram.sv
// Scoreboard bench for data_ram: randomized requests checked against an array model.
// Honours DATA_RAM_CLEAR_EN to exercise the zero-fill sweep.
module tb_data_ram;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned DEPTH = 2 ** AW;
`ifdef DATA_RAM_CLEAR_EN
  localparam logic EXP_BUSY = 1'b1;
`else
  localparam logic EXP_BUSY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [SW-1:0] wstrb = '0;
  logic          rsp_valid;
  logic [DW-1:0] rdata;
  logic          init_busy;

  data_ram #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .we(we), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rsp_valid(rsp_valid), .rdata(rdata), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    bit            known;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model [DEPTH];
  bit            known [DEPTH];
  logic [DW-1:0] last_rdata = '0;
  bit            last_known = 1'b1;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response is due in the cycle after the accepting edge, so any queued entry must be presented now.
  always @(negedge clk) begin
    if (!rst) begin
      exp_t e;
      bit   pending;
      pending = (exp_q.size() != 0);
      chk("rsp_valid", rsp_valid, pending);
      if (pending) begin
        e = exp_q.pop_front();
        if (e.known) chk("rdata", rdata, e.data);
        last_rdata = e.data;
        last_known = e.known;
      end else if (last_known) begin
        chk("rdata_hold", rdata, last_rdata);
      end
    end
  end

  task automatic issue(input bit w, input int a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    chk("req_ready", req_ready, 1'b1);
    req_valid = 1'b1;
    we        = w;
    addr      = a[AW-1:0];
    wdata     = d;
    wstrb     = s;
    tick();
    if (w) begin
      for (int i = 0; i < int'(SW); i++) begin
        if (s[i]) model[a][8*i +: 8] = d[8*i +: 8];
      end
      known[a] = known[a] || (s == '1);
    end else begin
      exp_q.push_back('{model[a], known[a]});
    end
    req_valid = 1'b0;
  endtask

  task automatic do_reset(input int abort_at);
    rst        = 1'b1;
    req_valid  = 1'b0;
    exp_q.delete();
    last_rdata = '0;
    last_known = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rdata", rdata, '0);
    chk("rst_init_busy", init_busy, EXP_BUSY);
    tick();
    tick();
    rst = 1'b0;
`ifdef DATA_RAM_CLEAR_EN
    for (int k = 1; k <= int'(DEPTH); k++) begin
      req_valid = 1'($urandom_range(0, 1));
      we        = 1'b0;
      addr      = AW'($urandom_range(0, DEPTH - 1));
      tick();
      if (k == abort_at) return;
      chk("sweep_init_busy", init_busy, k < int'(DEPTH));
      chk("sweep_req_ready", req_ready, k == int'(DEPTH));
    end
    req_valid = 1'b0;
    for (int a = 0; a < int'(DEPTH); a++) begin
      model[a] = '0;
      known[a] = 1'b1;
    end
`else
    chk("pre_edge_req_ready", req_ready, 1'b0);
    tick();
    chk("first_edge_req_ready", req_ready, 1'b1);
    chk("first_edge_init_busy", init_busy, 1'b0);
`endif
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < int'(DEPTH); a++) begin
      model[a] = '0;
      known[a] = 1'b0;
    end
    #2;
`ifdef DATA_RAM_CLEAR_EN
    do_reset(0);
    issue(1'b0, 17, '0, '0);
    do_reset(10);
    do_reset(0);
    issue(1'b0, 17, '0, '0);
    issue(1'b0, 31, '0, '0);
`else
    do_reset(0);
    issue(1'b1, 9, 32'hCAFE_F00D, 4'b1111);
    issue(1'b0, 9, '0, '0);
`endif
    for (int a = 0; a < int'(DEPTH); a++) begin
      issue(1'b1, a, $urandom, 4'b1111);
    end
    tick();

    issue(1'b1, 3, 32'hDEAD_BEEF, 4'b1111);
    issue(1'b0, 3, '0, '0);
    tick();
    issue(1'b1, 3, 32'h1122_3344, 4'b0101);
    issue(1'b0, 3, '0, '0);
    issue(1'b1, 3, 32'h5566_7788, 4'b0000);
    issue(1'b0, 3, '0, '0);
    issue(1'b1, 0, 32'h0000_000A, 4'b1111);
    issue(1'b1, 1, 32'h0000_000B, 4'b1111);
    issue(1'b0, 0, '0, '0);
    issue(1'b0, 1, '0, '0);
    tick();
    tick();

    // Reset with a response on the bus must drop it immediately.
    issue(1'b0, 1, '0, '0);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("inflight_rsp_valid", rsp_valid, 1'b0);
    chk("inflight_rdata", rdata, '0);
    do_reset(0);

    for (int n = 0; n < 400; n++) begin
      int unsigned kind;
      kind = $urandom_range(0, 9);
      if (kind < 2) begin
        tick();
      end else if (kind < 6) begin
        issue(1'b1, int'($urandom_range(0, DEPTH - 1)), $urandom, SW'($urandom));
      end else begin
        issue(1'b0, int'($urandom_range(0, DEPTH - 1)), '0, '0);
      end
    end
    tick();
    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
